// File: rtl/sync_ctrl_pkg.sv
// Shared definitions for the PPS-driven sync sequencer.
// Holds the controller state encoding, counter widths, parameter
// defaults and saturating-increment helpers used by sync_seq_ctrl.
package sync_ctrl_pkg;

    localparam int PPS_CNT_W       = 4;
    localparam int TO_CNT_W        = 16;
    localparam int ATT_W           = 4;

    localparam int N_PPS_WAIT_DEF  = 2;
    localparam int TIMEOUT_CYC_DEF = 64;
    localparam int MAX_RETRY_DEF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PPS = 3'd1,
        ST_ARM      = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PPS_CNT_W-1:0] pps_cnt_inc(input logic [PPS_CNT_W-1:0] v);
        if (v == {PPS_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(PPS_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TO_CNT_W-1:0] to_cnt_inc(input logic [TO_CNT_W-1:0] v);
        if (v == {TO_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(TO_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/pps_sync_edge.sv
// Brings the asynchronous PPS pin into the clk10 domain and produces a
// registered one-cycle pulse on each synchronized rising edge.
// The pulse appears three clk10 edges after the pin is first sampled high
// (two synchronizer stages, then the registered edge detector).
// Ports:
//   clk10 - system clock
//   rst   - asynchronous active-low reset
//   din   - asynchronous input (pps pin)
//   rise  - one-cycle pulse per synchronized rising edge
module pps_sync_edge (
    input  logic clk10,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic sync_q_r;
    logic rise_r;

    // Two-stage synchronizer, delayed copy and registered edge pulse.
    always_ff @(posedge clk10 or negedge rst) begin
        if (!rst) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            sync_q_r <= 1'b0;
            rise_r   <= 1'b0;
        end else begin
            meta_r   <= din;
            sync_r   <= meta_r;
            sync_q_r <= sync_r;
            rise_r   <= sync_r & ~sync_q_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/sync_seq_ctrl.sv
// Sequencer that waits for N_PPS_WAIT synchronized PPS edges, then raises
// sync_trigger until the sync block answers with a sync_ltc_fb rising edge.
// A silent trigger window of TIMEOUT_CYC cycles starts another attempt,
// up to MAX_RETRY attempts, after which a sticky err_timeout is raised.
// Ports:
//   clk10        - system clock
//   rst          - asynchronous active-low reset
//   pps          - asynchronous pulse-per-second input
//   sw_start     - one-cycle start request (ignored while busy)
//   sw_abort     - one-cycle cancel request (wins over everything)
//   sync_ltc_fb  - feedback from the sync block, clk10 domain
//   sync_trigger - trigger to the sync block
//   busy         - controller not idle
//   done         - one-cycle success pulse
//   err_timeout  - sticky failure flag, cleared by the next accepted start
//   attempts     - attempts started in the current or last sequence
module sync_seq_ctrl
    import sync_ctrl_pkg::*;
#(
    parameter int N_PPS_WAIT  = N_PPS_WAIT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic             clk10,
    input  logic             rst,
    input  logic             pps,
    input  logic             sw_start,
    input  logic             sw_abort,
    input  logic             sync_ltc_fb,
    output logic             sync_trigger,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [ATT_W-1:0] attempts
);

    localparam logic [PPS_CNT_W-1:0] N_PPS_L     = PPS_CNT_W'(N_PPS_WAIT);
    localparam logic [TO_CNT_W-1:0]  TO_LAST_L   = TO_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ATT_W-1:0]     MAX_RETRY_L = ATT_W'(MAX_RETRY);
    localparam logic [ATT_W-1:0]     ATT_ONE_L   = {{(ATT_W-1){1'b0}}, 1'b1};

    state_e                 state_r;
    state_e                 state_s;
    logic [PPS_CNT_W-1:0]   pps_cnt_r;
    logic [PPS_CNT_W-1:0]   pps_cnt_s;
    logic [PPS_CNT_W-1:0]   pps_inc_s;
    logic [TO_CNT_W-1:0]    to_cnt_r;
    logic [TO_CNT_W-1:0]    to_cnt_s;
    logic [ATT_W-1:0]       att_r;
    logic [ATT_W-1:0]       att_s;
    logic                   err_r;
    logic                   err_s;
    logic                   fb_q_r;
    logic                   fb_edge_s;
    logic                   pps_rise_s;
    logic                   trig_r;
    logic                   busy_r;
    logic                   done_r;

    pps_sync_edge u_pps_sync (
        .clk10 (clk10),
        .rst   (rst),
        .din   (pps),
        .rise  (pps_rise_s)
    );

    assign fb_edge_s = sync_ltc_fb & ~fb_q_r;
    assign pps_inc_s = pps_cnt_inc(pps_cnt_r);

    // Next-state and next-counter logic; abort overrides every state.
    always_comb begin
        state_s   = state_r;
        pps_cnt_s = pps_cnt_r;
        to_cnt_s  = to_cnt_r;
        att_s     = att_r;
        err_s     = err_r;
        if (sw_abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sw_start) begin
                        state_s   = ST_WAIT_PPS;
                        pps_cnt_s = {PPS_CNT_W{1'b0}};
                        err_s     = 1'b0;
                        att_s     = ATT_ONE_L;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end
                ST_WAIT_PPS: begin
                    if (pps_rise_s) begin
                        pps_cnt_s = pps_inc_s;
                        if (pps_inc_s >= N_PPS_L) begin
                            state_s  = ST_ARM;
                            to_cnt_s = {TO_CNT_W{1'b0}};
                        end else begin
                            state_s  = ST_WAIT_PPS;
                        end
                    end else begin
                        state_s = ST_WAIT_PPS;
                    end
                end
                ST_ARM: begin
                    // A feedback edge on the last window cycle still counts as success.
                    if (fb_edge_s) begin
                        state_s = ST_DONE;
                    end else if (to_cnt_r >= TO_LAST_L) begin
                        if (att_r < MAX_RETRY_L) begin
                            state_s   = ST_WAIT_PPS;
                            att_s     = att_r + ATT_ONE_L;
                            pps_cnt_s = {PPS_CNT_W{1'b0}};
                        end else begin
                            state_s   = ST_ERR;
                            err_s     = 1'b1;
                        end
                    end else begin
                        to_cnt_s = to_cnt_inc(to_cnt_r);
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                ST_ERR: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk10 or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            pps_cnt_r <= {PPS_CNT_W{1'b0}};
            to_cnt_r  <= {TO_CNT_W{1'b0}};
            att_r     <= {ATT_W{1'b0}};
            err_r     <= 1'b0;
            fb_q_r    <= 1'b0;
            trig_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pps_cnt_r <= pps_cnt_s;
            to_cnt_r  <= to_cnt_s;
            att_r     <= att_s;
            err_r     <= err_s;
            fb_q_r    <= sync_ltc_fb;
            trig_r    <= (state_s == ST_ARM);
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign sync_trigger = trig_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_timeout  = err_r;
    assign attempts     = att_r;

endmodule

// File: tb/tb_sync_seq_ctrl.sv
// Directed bench for sync_seq_ctrl: expected values are queued as each
// stimulus step is driven and compared when the DUT response is sampled.
module tb_sync_seq_ctrl;

    logic       clk10 = 1'b0;
    logic       rst;
    logic       pps;
    logic       sw_start;
    logic       sw_abort;
    logic       sync_ltc_fb;
    logic       sync_trigger;
    logic       busy;
    logic       done;
    logic       err_timeout;
    logic [3:0] attempts;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk10 = ~clk10;

    sync_seq_ctrl dut (
        .clk10        (clk10),
        .rst          (rst),
        .pps          (pps),
        .sw_start     (sw_start),
        .sw_abort     (sw_abort),
        .sync_ltc_fb  (sync_ltc_fb),
        .sync_trigger (sync_trigger),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .attempts     (attempts)
    );

    task automatic tick();
        @(negedge clk10);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            e.tag = "<empty>";
            e.val = 32'hDEAD_BEEF;
        end else begin
            e = exp_q.pop_front();
        end
        n_checks++;
        assert (obs === e.val && e.tag == tag) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (queued tag %s)", tag, obs, e.val, e.tag);
        end
    endtask

    task automatic expect_outs(input string p, input logic t, input logic b,
                               input logic d, input logic e, input logic [3:0] a);
        expect_val({p, "_trig"}, {31'd0, t});
        expect_val({p, "_busy"}, {31'd0, b});
        expect_val({p, "_done"}, {31'd0, d});
        expect_val({p, "_err"},  {31'd0, e});
        expect_val({p, "_att"},  {28'd0, a});
    endtask

    task automatic check_outs(input string p);
        check({p, "_trig"}, {31'd0, sync_trigger});
        check({p, "_busy"}, {31'd0, busy});
        check({p, "_done"}, {31'd0, done});
        check({p, "_err"},  {31'd0, err_timeout});
        check({p, "_att"},  {28'd0, attempts});
    endtask

    task automatic pulse_start();
        sw_start = 1'b1;
        tick();
        sw_start = 1'b0;
    endtask

    task automatic pulse_abort();
        sw_abort = 1'b1;
        tick();
        sw_abort = 1'b0;
    endtask

    task automatic pps_pulse();
        pps = 1'b1;
        tick();
        pps = 1'b0;
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            tick();
            if (sync_trigger === 1'b1) c++;
        end
    endtask

    // First pps must not trigger; returns ticks from second pps pin rise to trigger.
    task automatic two_pps(output int early, output int lat);
        pps_pulse();
        count_high(7, early);
        pps = 1'b1;
        tick();
        pps = 1'b0;
        lat = 1;
        while (sync_trigger !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Counts trigger-high cycles; pulses fb on the fb_at-th high cycle (0 = never).
    task automatic arm_window(input int fb_at, output int hi);
        hi = 0;
        while (sync_trigger === 1'b1 && hi < 200) begin
            hi++;
            if (hi == fb_at) sync_ltc_fb = 1'b1;
            tick();
            sync_ltc_fb = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int early;
        int lat;
        int hi;
        int c1;
        int c2;
        int d;

        rst         = 1'b0;
        pps         = 1'b0;
        sw_start    = 1'b0;
        sw_abort    = 1'b0;
        sync_ltc_fb = 1'b0;

        // Reset state
        expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) tick();
        check_outs("reset");
        rst = 1'b1;
        repeat (2) tick();

        // Nominal sequence
        expect_val("nom_busy", 32'd1);
        pulse_start();
        check("nom_busy", {31'd0, busy});
        expect_val("nom_early", 32'd0);
        expect_val("nom_lat", 32'd4);
        two_pps(early, lat);
        check("nom_early", early);
        check("nom_lat", lat);
        expect_val("nom_hi", 32'd10);
        expect_outs("nom_fb", 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        arm_window(10, hi);
        check("nom_hi", hi);
        check_outs("nom_fb");
        expect_outs("nom_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        tick();
        check_outs("nom_end");

        // Retry: two silent windows, success on the third attempt
        pulse_start();
        for (int a = 1; a <= 3; a++) begin
            expect_val("rty_lat", 32'd4);
            expect_val("rty_hi", (a < 3) ? 32'd64 : 32'd10);
            expect_outs("rty_win", 1'b0, 1'b1, (a == 3), 1'b0, 4'((a < 3) ? a + 1 : 3));
            two_pps(early, lat);
            check("rty_lat", lat);
            arm_window((a == 3) ? 10 : 0, hi);
            check("rty_hi", hi);
            check_outs("rty_win");
            if (a == 1) begin
                expect_val("busy_start_att", 32'd2);
                pulse_start();
                check("busy_start_att", {28'd0, attempts});
            end
        end
        expect_outs("rty_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        tick();
        check_outs("rty_end");

        // Failure: three silent windows end in the error state
        pulse_start();
        for (int a = 1; a <= 3; a++) begin
            expect_val("fail_hi", 32'd64);
            expect_outs("fail_win", 1'b0, 1'b1, 1'b0, (a == 3), 4'((a < 3) ? a + 1 : 3));
            two_pps(early, lat);
            arm_window(0, hi);
            check("fail_hi", hi);
            check_outs("fail_win");
        end
        expect_outs("fail_idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        tick();
        check_outs("fail_idle");
        expect_outs("fail_restart", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        pulse_start();
        check_outs("fail_restart");
        pulse_abort();

        // Abort during ARM
        pulse_start();
        two_pps(early, lat);
        repeat (5) tick();
        expect_outs("abort", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        pulse_abort();
        check_outs("abort");
        expect_val("abort_no_done", 32'd0);
        d = 0;
        repeat (10) begin
            tick();
            if (done !== 1'b0) d++;
        end
        check("abort_no_done", d);

        // Start and abort together in IDLE
        expect_val("start_abort_busy", 32'd0);
        sw_start = 1'b1;
        sw_abort = 1'b1;
        tick();
        sw_start = 1'b0;
        sw_abort = 1'b0;
        tick();
        check("start_abort_busy", {31'd0, busy});

        // Boundary: fb ignored in WAIT_PPS, fb edge on the last ARM cycle wins
        pulse_start();
        expect_val("wait_fb_busy", 32'd1);
        expect_val("wait_fb_done", 32'd0);
        sync_ltc_fb = 1'b1;
        tick();
        sync_ltc_fb = 1'b0;
        tick();
        check("wait_fb_busy", {31'd0, busy});
        check("wait_fb_done", {31'd0, done});
        expect_val("bnd_lat", 32'd4);
        expect_val("bnd_hi", 32'd64);
        expect_outs("bnd_fb", 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        two_pps(early, lat);
        check("bnd_lat", lat);
        arm_window(64, hi);
        check("bnd_hi", hi);
        check_outs("bnd_fb");
        tick();

        // Asynchronous reset during ARM
        pulse_start();
        two_pps(early, lat);
        repeat (3) tick();
        expect_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst");
        tick();
        rst = 1'b1;
        tick();
        expect_val("post_rst_trig", 32'd0);
        expect_val("post_rst_busy", 32'd0);
        pps_pulse();
        count_high(8, c1);
        pps_pulse();
        count_high(12, c2);
        check("post_rst_trig", c1 + c2);
        check("post_rst_busy", {31'd0, busy});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_seq_ctrl.md
SYNC_SEQ_CTRL -- requirements
Module: sync_seq_ctrl

Interface
REQ-001 Parameter N_PPS_WAIT, default 2: synchronized PPS rising edges counted before sync_trigger is asserted.
REQ-002 Parameter TIMEOUT_CYC, default 64: clk10 cycles sync_trigger may stay high without a sync_ltc_fb rising edge.
REQ-003 Parameter MAX_RETRY, default 3: attempts before error; legal range 1..15.
REQ-004 clk10  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 pps  in  1  asynchronous pulse-per-second input.
REQ-007 sw_start  in  1  one-cycle request to start a sync sequence.
REQ-008 sw_abort  in  1  one-cycle request to cancel the sequence.
REQ-009 sync_ltc_fb  in  1  sync_ltc output of the sync block, clk10 domain.
REQ-010 sync_trigger  out  1  trigger to the sync block.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 done  out  1  one-cycle pulse on successful sync.
REQ-013 err_timeout  out  1  sticky error after MAX_RETRY failed attempts.
REQ-014 attempts  out  4  attempts started in the current or last sequence.

Function
REQ-015 pps SHALL pass through a 2-FF synchronizer plus an edge register; pps_rise is a one-cycle pulse 3 cycles after the pin rises.
REQ-016 States SHALL be IDLE, WAIT_PPS, ARM, DONE and ERR; all outputs registered.
REQ-017 IDLE: sw_start -> WAIT_PPS; clear pps_cnt, clear err_timeout, set attempts=1.
REQ-018 WAIT_PPS: each pps_rise increments pps_cnt; on the N_PPS_WAIT-th pps_rise -> ARM, with sync_trigger high on the next cycle.
REQ-019 ARM: sync_trigger high; timeout counter increments each cycle from 0.
REQ-020 ARM, sync_ltc_fb rising edge (fb & ~fb_q) -> DONE; sync_trigger low on the next cycle.
REQ-021 ARM, timeout counter reaches TIMEOUT_CYC-1 without an fb edge: if attempts < MAX_RETRY -> WAIT_PPS, attempts+1, pps_cnt cleared; otherwise -> ERR. sync_trigger goes low in both cases.
REQ-022 Simultaneous fb edge and final timeout cycle: the fb edge wins (success).
REQ-023 DONE: done pulses for 1 cycle -> IDLE.
REQ-024 ERR: err_timeout set, held until the next accepted sw_start -> IDLE after 1 cycle.
REQ-025 sw_start while busy SHALL be ignored; attempts unchanged.
REQ-026 sw_abort in any state -> IDLE next cycle; sync_trigger low, no done, err_timeout unchanged.
REQ-027 sw_start and sw_abort in the same IDLE cycle: abort wins; no sequence starts.
REQ-028 sync_ltc_fb edges outside ARM SHALL be ignored.
REQ-029 attempts SHALL never exceed MAX_RETRY; pps_cnt and the timeout counter saturate and never wrap.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, synchronizer flops 0, fb_q 0, all counters 0, and sync_trigger/busy/done/err_timeout/attempts 0.
REQ-031 Reset deassertion mid-sequence SHALL restart from IDLE; no trigger until a new sw_start.

Structure
REQ-032 Package sync_ctrl_pkg SHALL hold the state enum, counter widths (PPS_CNT_W=4, TO_CNT_W=16, ATT_W=4) and parameter defaults.
REQ-033 Sub-module pps_sync_edge (2-FF sync + rising-edge pulse) SHALL be instantiated once for pps.

Verification
REQ-034 Nominal: sw_start, 2 pps pulses, fb pulse 10 cycles after trigger rises -> trigger high from 1 cycle after 2nd pps_rise, low 1 cycle after fb edge, done=1 for 1 cycle, attempts=1.
REQ-035 Retry: no fb on attempts 1-2, fb on attempt 3 -> trigger high for 64 cycles twice, done pulse, attempts=3, err_timeout=0.
REQ-036 Failure: fb never asserted -> 3 trigger windows of 64 cycles, then err_timeout=1, busy=0; next sw_start clears err_timeout.
REQ-037 Abort: sw_abort during ARM -> sync_trigger low next cycle, busy=0, no done; start+abort in the same cycle -> busy stays 0.
REQ-038 Reset: rst low during ARM -> sync_trigger=0 immediately (asynchronous); after release, pps pulses alone produce no trigger.
REQ-039 Boundary: fb edge on the 64th ARM cycle -> success, attempts unchanged; sw_start while busy -> ignored; fb during WAIT_PPS -> ignored.
